// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared states, owner/length codes and helpers for the IF/MEM RAM sequencer
package mem_ctrl_pkg;

  localparam int MC_ADDR_W = 32;
  localparam int MC_DATA_W = 32;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2,
    MC_DONE = 2'd3
  } mc_state_t;

  typedef enum logic {
    MC_OWN_IF  = 1'b0,
    MC_OWN_MEM = 1'b1
  } mc_owner_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  // The unused code 2 is folded into a full word.
  function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - requester and byte-RAM signals of the shared memory port
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_cancel_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_done_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_len_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_done_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic [7:0]        ram_dout_o;
  logic              ram_wr_o;
  logic [7:0]        ram_din_i;
  logic              stall_if_o;
  logic              stall_mem_o;

  modport slave (
    input  if_req_i, if_addr_i, if_cancel_i,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o,
    output ram_a_o, ram_dout_o, ram_wr_o, stall_if_o, stall_mem_o
  );

  modport master (
    output if_req_i, if_addr_i, if_cancel_i,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o,
    input  ram_a_o, ram_dout_o, ram_wr_o, stall_if_o, stall_mem_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates IF/MEM onto a byte-wide synchronous RAM, one byte per cycle
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  mem_ctrl_if.slave   bus
);

  mc_state_t         state, state_nxt;
  mc_owner_t         owner;
  logic [2:0]        cnt;
  logic [2:0]        nbyte;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] asm_q, asm_nxt;
  logic [DATA_W-1:0] if_data, mem_rdata;
  logic              cancel;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic              if_done, mem_done;

  assign cancel = (state == MC_RD) && (owner == MC_OWN_IF) && bus.if_cancel_i;

  // Byte cnt-1 arrives this cycle for the address driven last cycle; cnt=4 maps to byte 3.
  always_comb begin
    asm_nxt = asm_q;
    if (cnt != 3'd0)
      asm_nxt[{cnt[1:0] - 2'd1, 3'b000} +: 8] = bus.ram_din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MC_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_a     = '0;
    ram_dout  = 8'h00;
    ram_wr    = 1'b0;
    if_done   = 1'b0;
    mem_done  = 1'b0;
    case (state)
      MC_IDLE: begin
        if (bus.mem_req_i)
          state_nxt = bus.mem_we_i ? MC_WR : MC_RD;
        else if (bus.if_req_i)
          state_nxt = MC_RD;
      end
      MC_RD: begin
        if (cnt < nbyte)
          ram_a = addr + ADDR_W'(cnt);
        if (cancel)
          state_nxt = MC_IDLE;
        else if (cnt == nbyte)
          state_nxt = MC_DONE;
      end
      MC_WR: begin
        ram_wr   = 1'b1;
        ram_a    = addr + ADDR_W'(cnt);
        ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
        if (cnt == nbyte - 3'd1)
          state_nxt = MC_DONE;
      end
      MC_DONE: begin
        if_done   = (owner == MC_OWN_IF);
        mem_done  = (owner == MC_OWN_MEM);
        state_nxt = MC_IDLE;
      end
      default: state_nxt = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= MC_OWN_IF;
      cnt       <= 3'd0;
      nbyte     <= 3'd0;
      addr      <= '0;
      wdata     <= '0;
      asm_q     <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (bus.mem_req_i || bus.if_req_i) begin
            cnt   <= 3'd0;
            asm_q <= '0;
          end
          if (bus.mem_req_i) begin
            owner <= MC_OWN_MEM;
            addr  <= bus.mem_addr_i;
            nbyte <= len_to_nbytes(bus.mem_len_i);
            wdata <= bus.mem_wdata_i;
          end else if (bus.if_req_i) begin
            owner <= MC_OWN_IF;
            addr  <= bus.if_addr_i;
            nbyte <= 3'd4;
          end
        end
        MC_RD: begin
          asm_q <= asm_nxt;
          if (cnt != nbyte)
            cnt <= cnt + 3'd1;
          else if (!cancel) begin
            if (owner == MC_OWN_IF) if_data   <= asm_nxt;
            else                    mem_rdata <= asm_nxt;
          end
        end
        MC_WR:   cnt <= cnt + 3'd1;
        default: ;
      endcase
    end
  end

  assign bus.ram_a_o     = ram_a;
  assign bus.ram_dout_o  = ram_dout;
  assign bus.ram_wr_o    = ram_wr;
  assign bus.if_done_o   = if_done;
  assign bus.mem_done_o  = mem_done;
  assign bus.if_data_o   = if_data;
  assign bus.mem_rdata_o = mem_rdata;
  assign bus.stall_if_o  = bus.if_req_i & ~if_done;
  assign bus.stall_mem_o = bus.mem_req_i & ~mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomized checks of mem_ctrl against a byte-array model
module tb_mem_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   wr_count;

  bit [7:0] ram     [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.ram_din_i <= ram.exists(bus.ram_a_o) ? ram[bus.ram_a_o] : 8'h00;
    if (bus.ram_wr_o) begin
      ram[bus.ram_a_o] = bus.ram_dout_o;
      wr_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // Caller is at a negedge with the DUT idle; returns at the negedge after the done cycle.
  task automatic run_access(input bit is_mem, input bit we, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input string tag, output logic [31:0] data);
    int          n, lat, done_at;
    bit          wr;
    logic [31:0] exp, a;
    n       = is_mem ? ((len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4) : 4;
    wr      = is_mem && we;
    lat     = wr ? n + 1 : n + 2;
    exp     = 32'h0;
    data    = 32'h0;
    done_at = -1;
    for (int i = 0; i < n; i++)
      if (!wr) exp[8*i +: 8] = ref_rd(addr + 32'(i));
    if (is_mem) begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_len_i   = len;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = wdata;
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
    end
    for (int c = 1; c <= lat + 3 && done_at < 0; c++) begin
      @(negedge clk);
      if (c <= n) begin
        a = addr + 32'(c - 1);
        check($sformatf("%s ram_a c%0d", tag, c), bus.ram_a_o, a);
        check($sformatf("%s ram_wr c%0d", tag, c), 32'(bus.ram_wr_o), 32'(wr));
        if (wr) begin
          check($sformatf("%s ram_dout c%0d", tag, c), 32'(bus.ram_dout_o), 32'(wdata[8*(c-1) +: 8]));
          ref_mem[a] = wdata[8*(c-1) +: 8];
        end
      end
      if (is_mem ? bus.mem_done_o : bus.if_done_o) begin
        done_at = c;
        data    = is_mem ? bus.mem_rdata_o : bus.if_data_o;
        check({tag, " other_done"}, 32'(is_mem ? bus.if_done_o : bus.mem_done_o), 32'h0);
        check({tag, " stall_at_done"}, 32'(is_mem ? bus.stall_mem_o : bus.stall_if_o), 32'h0);
      end else begin
        check($sformatf("%s stall c%0d", tag, c), 32'(is_mem ? bus.stall_mem_o : bus.stall_if_o), 32'h1);
      end
    end
    bus.mem_req_i = 1'b0;
    bus.if_req_i  = 1'b0;
    check({tag, " latency"}, 32'(done_at), 32'(lat));
    if (!wr) check({tag, " rdata"}, data, exp);
    else for (int i = 0; i < n; i++)
      check($sformatf("%s ram byte%0d", tag, i), 32'(ram[addr + 32'(i)]), 32'(ref_rd(addr + 32'(i))));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d, last_if;
    int          if_done_at, mem_done_at, wc;
    bit          is_mem, we;
    logic [1:0]  len;
    logic [31:0] addr;
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    rst             = 1'b1;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'h0;
    bus.if_cancel_i = 1'b0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_len_i   = 2'd0;
    bus.mem_addr_i  = 32'h0;
    bus.mem_wdata_i = 32'h0;
    repeat (3) @(negedge clk);
    check("rst if_data", bus.if_data_o, 32'h0);
    check("rst mem_rdata", bus.mem_rdata_o, 32'h0);
    check("rst if_done", 32'(bus.if_done_o), 32'h0);
    check("rst mem_done", 32'(bus.mem_done_o), 32'h0);
    check("rst ram_wr", 32'(bus.ram_wr_o), 32'h0);
    check("rst ram_a", bus.ram_a_o, 32'h0);
    check("rst ram_dout", 32'(bus.ram_dout_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // IF word fetch of an addi instruction
    preload(32'h100, 8'h13); preload(32'h101, 8'h00);
    preload(32'h102, 8'h50); preload(32'h103, 8'h00);
    run_access(1'b0, 1'b0, 2'd3, 32'h100, 32'h0, "if_word", d);
    check("if_word const", d, 32'h0050_0013);
    last_if = d;

    run_access(1'b1, 1'b1, 2'd3, 32'h2000, 32'hDEAD_BEEF, "st_word", d);
    check("st_word bytes", {ram[32'h2003], ram[32'h2002], ram[32'h2001], ram[32'h2000]}, 32'hDEAD_BEEF);

    preload(32'h3003, 8'h80);
    run_access(1'b1, 1'b0, 2'd0, 32'h3003, 32'h0, "ld_byte", d);
    check("ld_byte const", d, 32'h0000_0080);

    // Simultaneous requests: MEM first, IF re-arbitrated after DONE
    for (int i = 0; i < 4; i++) begin
      preload(32'h0 + 32'(i), 8'(8'hA0 + i));
      preload(32'h10 + 32'(i), 8'(8'h50 + i));
    end
    bus.if_req_i   = 1'b1; bus.if_addr_i  = 32'h0;
    bus.mem_req_i  = 1'b1; bus.mem_we_i   = 1'b0;
    bus.mem_len_i  = 2'd3; bus.mem_addr_i = 32'h10;
    if_done_at = -1; mem_done_at = -1;
    for (int c = 0; c <= 15 && if_done_at < 0; c++) begin
      if (c == 0) #1; else @(negedge clk);
      if (bus.mem_done_o && mem_done_at < 0) begin
        mem_done_at = c;
        check("both mem_rdata", bus.mem_rdata_o, 32'h5352_5150);
        bus.mem_req_i = 1'b0;
      end
      if (bus.if_done_o) begin
        if_done_at = c;
        check("both if_data", bus.if_data_o, 32'hA3A2_A1A0);
        bus.if_req_i = 1'b0;
      end else if (bus.stall_if_o !== 1'b1) begin
        check($sformatf("both stall_if c%0d", c), 32'(bus.stall_if_o), 32'h1);
      end
    end
    bus.if_req_i = 1'b0; bus.mem_req_i = 1'b0;
    check("both mem_done_at", 32'(mem_done_at), 32'd6);
    check("both if_done_at", 32'(if_done_at), 32'd13);
    last_if = 32'hA3A2_A1A0;
    @(negedge clk);

    // IF cancel during cnt=2, redirected fetch to 0x80
    for (int i = 0; i < 4; i++) begin
      preload(32'h40 + 32'(i), 8'(8'h11 * (i + 1)));
      preload(32'h80 + 32'(i), 8'(8'hC0 + i));
    end
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
    if_done_at = -1;
    for (int c = 1; c <= 13 && if_done_at < 0; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.if_cancel_i = 1'b1;
        bus.if_addr_i   = 32'h80;
      end
      if (c == 4) begin
        bus.if_cancel_i = 1'b0;
        check("cancel if_data held", bus.if_data_o, last_if);
      end
      if (bus.if_done_o) begin
        if_done_at = c;
        check("cancel new data", bus.if_data_o, 32'hC3C2_C1C0);
        bus.if_req_i = 1'b0;
      end
    end
    bus.if_req_i = 1'b0; bus.if_cancel_i = 1'b0;
    check("cancel done_at", 32'(if_done_at), 32'd10);
    @(negedge clk);

    // Reset during cnt=1 of a word store
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'd3;
    bus.mem_addr_i = 32'h7000; bus.mem_wdata_i = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; bus.mem_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstwr ram_wr", 32'(bus.ram_wr_o), 32'h0);
    check("rstwr mem_done", 32'(bus.mem_done_o), 32'h0);
    check("rstwr if_done", 32'(bus.if_done_o), 32'h0);
    check("rstwr if_data", bus.if_data_o, 32'h0);
    wc = wr_count;
    repeat (6) @(negedge clk);
    check("rstwr no writes", 32'(wr_count - wc), 32'h0);

    // Randomized mix over a preloaded window and the top-of-memory wrap
    for (int i = 0; i < 64; i++) preload(32'h5000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 4; i++)  preload(32'hFFFF_FFFC + 32'(i), 8'($urandom));
    for (int t = 0; t < 30; t++) begin
      is_mem = 1'($urandom_range(0, 2) != 0);
      we     = 1'($urandom);
      len    = 2'($urandom);
      addr   = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                            : 32'h5000 + 32'($urandom_range(0, 60));
      run_access(is_mem, we, len, addr, $urandom, $sformatf("rnd%0d", t), d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Arbiter and sequencer that shares one byte-wide synchronous RAM port between instruction fetch (IF) and the load/store stage (MEM) of the RV32I pipeline. It breaks each 1/2/4-byte access into single-byte RAM cycles, assembles or scatters the data little-endian, and returns a one-cycle done pulse to the requester. It also raises stall requests to the pipeline control while an access is outstanding.

Parameters:
ADDR_W, 32, byte address width on all address ports.
DATA_W, 32, requester data width; fixed at 4 bytes.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  synchronous reset, active-high (rst == `RstEnable).
if_req_i  in  1  IF word-read request; level, held until if_done_o.
if_addr_i  in  ADDR_W  IF fetch address.
if_cancel_i  in  1  abort the in-flight IF read (branch/jump redirect).
if_data_o  out  DATA_W  fetched instruction; valid while if_done_o=1.
if_done_o  out  1  one-cycle completion pulse for IF.
mem_req_i  in  1  MEM request; level, held until mem_done_o.
mem_we_i  in  1  1 = store, 0 = load.
mem_len_i  in  2  bytes-1: 0 = byte, 1 = half, 3 = word; 2 is illegal and treated as 3.
mem_addr_i  in  ADDR_W  MEM byte address.
mem_wdata_i  in  DATA_W  store data; byte k is taken from bits [8k+7:8k].
mem_rdata_o  out  DATA_W  load data, zero-extended above len; valid while mem_done_o=1.
mem_done_o  out  1  one-cycle completion pulse for MEM.
ram_a_o  out  ADDR_W  RAM byte address.
ram_dout_o  out  8  RAM write byte.
ram_wr_o  out  1  RAM write strobe.
ram_din_i  in  8  RAM read byte; valid the cycle after its address is driven.
stall_if_o  out  1  if_req_i & ~if_done_o.
stall_mem_o  out  1  mem_req_i & ~mem_done_o.

Behaviour:
- States: IDLE, RD, WR, DONE. Owner register: IF or MEM. Byte counter cnt holds 0..4. N = len+1 (IF: N=4).
- Reset (synchronous): state=IDLE and cnt=0. Registered outputs clear next edge: if_data_o=0, mem_rdata_o=0, if_done_o=0, mem_done_o=0, ram_wr_o=0, ram_a_o=0, ram_dout_o=0.
- IDLE: on an edge where any request is high, latch the winner's address/len/we/wdata and set cnt=0.
  - MEM has fixed priority over IF.
  - Load or IF → RD; store → WR. No request → stay IDLE.
- RD, cycle with cnt=k:
  - If k<N: ram_a_o = addr+k.
  - If k≥1: capture ram_din_i into byte k-1 of the assembly register.
  - k==N → DONE; otherwise cnt++.
- WR, cycle with cnt=k: ram_wr_o=1, ram_a_o=addr+k, ram_dout_o=wdata byte k. k==N-1 → DONE.
- DONE: lasts exactly one cycle.
  - The owner's done_o=1 and its data output is valid; the non-owner's done_o stays 0.
  - Requests are ignored in DONE; the next state is IDLE, so a held request is re-arbitrated one cycle later.
- Latency, with request first sampled in IDLE cycle T:
  - Read of N bytes: done in cycle T+N+2 (word read: T+6).
  - Write of N bytes: done in cycle T+N+1 (word write: T+5).
- Address arithmetic is modulo 2^ADDR_W: a word at 0xFFFFFFFE wraps to 0x0 and 0x1.
- Simultaneous if_req_i and mem_req_i in IDLE: MEM is served first, then IF; IF waits, stall_if_o stays high.
- A request arriving mid-transaction waits. No preemption, so a MEM request waits behind an in-flight IF.
- if_cancel_i sampled high while owner=IF in RD:
  - Go to IDLE next cycle. No if_done_o, if_data_o unchanged.
  - The new IF request is arbitrated normally from IDLE.
  - if_cancel_i is ignored in all other states and owners.
- Reset asserted mid-WR: ram_wr_o is 0 from the next cycle. A partially written word is acceptable; the pipeline is flushed on reset.
- Unused upper bytes of mem_rdata_o are 0. Sign extension for LB/LH is done by the MEM stage.

Decomposition:
- In defines.v:
  - state encodings MC_IDLE/MC_RD/MC_WR/MC_DONE;
  - owner codes MC_OWN_IF/MC_OWN_MEM;
  - length codes LEN_BYTE/LEN_HALF/LEN_WORD;
  - existing `RstEnable, `WriteEnable, `ZeroWord.
- Single module, no sub-module. The byte insert/extract logic is small enough to stay inline.

Test Plan:
1. Reset mid-WR: assert rst during cnt=1 of a word store → next cycle ram_wr_o=0, state IDLE, all done outputs 0, and no further RAM writes.
2. IF word read, RAM bytes at 0x100..0x103 = 13,00,50,00 (hex): if_req_i=1 at T → ram_a_o 0x100..0x103 in T+1..T+4, if_done_o=1 only in T+6, if_data_o=0x00500013.
3. MEM store, len=3, addr 0x2000, wdata 0xDEADBEEF → ram_wr_o=1 for T+1..T+4 with bytes EF,BE,AD,DE at 0x2000..0x2003; mem_done_o in T+5; stall_mem_o low at T+5.
4. MEM load byte, len=0, addr 0x3003, RAM byte 0x80 → mem_rdata_o=0x00000080 and mem_done_o in T+3; only one RAM address driven.
5. Both requests at T (IF 0x0, MEM load word 0x10) → MEM done at T+6; IF starts in IDLE at T+7 and is done at T+13; stall_if_o high T..T+12.
6. IF read at 0x40, if_cancel_i=1 during cnt=2 → IDLE next cycle, no if_done_o pulse; a new if_req_i to 0x80 completes with the 0x80 data.
